ahb_lite_ram_slave: RTL and testbench

//  AHB-Lite responder (subordinate) memory for the multicycle ARM core's AHB master port.
//  - Accepts the address phase and registers it.
//  - Serves the data phase with a programmable number of wait states.
//  - Supports byte, halfword and word writes via byte lanes.
//  - Signals a two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_lite_ram_slave.sv | 141 ++++++++++++++
 tb/tb_ahb_lite_ram_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite subordinate RAM. It registers the address phase and serves the
// data phase after a fixed number of wait states. Writes use byte lanes.
// An illegal size or a misaligned transfer gets the two-cycle ERROR response.
module ahb_lite_ram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          open_slot, accept, take, illegal;
  logic [3:0]    lane_en;
  logic [31:0]   mem [0:MEM_WORDS-1];

  // Upper address bits alias onto the array. HTRANS[0] (SEQ vs NONSEQ) does not
  // matter to a RAM.
  logic          unused_bits;
  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  // Decode the address phase. A new transfer is taken only in a cycle where
  // the previous data phase is closing (or there is none).
  always_comb begin
    open_slot = (state == ST_IDLE) || (state == ST_ACCESS) || (state == ST_ERR2);
    accept    = HSEL & HREADY & HTRANS[1];
    take      = open_slot & accept;
    illegal   = (HSIZE > SZ_WORD)
             || ((HSIZE == SZ_HALF) && HADDR[0])
             || ((HSIZE == SZ_WORD) && (HADDR[1:0] != 2'b00));
  end

  // Next state and wait counter. IDLE, ACCESS and ERR2 all dispatch on the
  // address phase, so transfers can run back to back.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that leaves one unassigned infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ST_ACCESS;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        if (!accept)          state_nxt = ST_IDLE;
        else if (illegal)     state_nxt = ST_ERR1;
        else if (WS == 4'd0)  state_nxt = ST_ACCESS;
        else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WS;
        end
      end
    endcase
  end

  // State register and registered bus responses. An async reset drops any
  // pending transfer at once.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      idx_q     <= '0;
      off_q     <= 2'b00;
      size_q    <= SZ_BYTE;
      write_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples the values from before the edge.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      HREADYOUT <= !((state_nxt == ST_WAIT) || (state_nxt == ST_ERR1));
      HRESP     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
      if (take) begin
        idx_q   <= HADDR[AW+1:2];
        off_q   <= HADDR[1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  end

  // Byte-lane enables for the registered transfer, little-endian. Only legal
  // sizes ever reach ACCESS.
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      SZ_BYTE: lane_en[off_q] = 1'b1;
      SZ_HALF: lane_en        = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en        = 4'b1111;
    endcase
  end

  // Commit the write on the edge that closes its ACCESS cycle.
  // NOTE: the memory array has no reset. Clearing a RAM is not possible in one cycle, and the bus never needs it cleared.
  always_ff @(posedge HCLK) begin
    if ((state == ST_ACCESS) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is visible only in the final data-phase cycle. A write committed
  // on the previous edge is therefore already visible to a back-to-back read.
  always_comb begin
    HRDATA = (state == ST_ACCESS) ? mem[idx_q] : 32'h0;
  end

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Directed bench for ahb_lite_ram_slave. One instance uses one wait state and
// a second uses zero wait states. The instance being exercised drives HREADY.
module tb_ahb_lite_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        use_ws0;
  logic        hready;
  logic [31:0] hrdata1, hrdata0, rdata_s;
  logic        hreadyout1, hreadyout0, hresp1, hresp0, resp_s;

  always #5 clk = ~clk;

  assign hready  = use_ws0 ? hreadyout0 : hreadyout1;
  assign resp_s  = use_ws0 ? hresp0     : hresp1;
  assign rdata_s = use_ws0 ? hrdata0    : hrdata1;

  ahb_lite_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(1)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
  );

  ahb_lite_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    int          exp_low;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } pvec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  // A single non-pipelined transfer. The task starts on a cycle with the bus
  // ready and returns just after the edge that closes the data phase.
  task automatic xfer(input vec_t v, output int nlow, output int bad,
                      output logic resp_fin, output logic [31:0] rdata, output logic done);
    nlow = 0; bad = 0; resp_fin = 1'b0; rdata = 32'h0; done = 1'b0;
    @(negedge clk);
    hsel = 1'b1; haddr = v.addr; htrans = 2'b10; hwrite = v.wr; hsize = v.size;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    hwdata = v.wdata;
    for (int k = 0; k < 40 && !done; k++) begin
      if (hready) begin
        done     = 1'b1;
        resp_fin = resp_s;
        rdata    = rdata_s;
      end else begin
        nlow++;
        if (resp_s !== v.err || rdata_s !== 32'h0) bad++;
        @(negedge clk);
      end
    end
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int          nlow, bad;
    logic        rf, done;
    logic [31:0] rd;
    xfer(v, nlow, bad, rf, rd, done);
    check({v.name, "/done"},  32'(done), 32'd1);
    check({v.name, "/low"},   32'(nlow), 32'(v.exp_low));
    check({v.name, "/resp"},  32'(rf),   32'(v.err));
    check({v.name, "/phase"}, 32'(bad),  32'd0);
    if (!v.wr && !v.err) check({v.name, "/rdata"}, rd, v.exp_rd);
  endtask

  vec_t  vecs [16];
  pvec_t pv   [8];
  vec_t  pre80, wr80, rd80;

  initial begin
    vecs[0]  = '{"w100",    1'b1, 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 1'b0, 1, 32'h0};
    vecs[1]  = '{"r100",    1'b0, 32'h0000_0100, 3'b010, 32'h0,         1'b0, 1, 32'hDEAD_BEEF};
    vecs[2]  = '{"w40",     1'b1, 32'h0000_0040, 3'b010, 32'h1122_3344, 1'b0, 1, 32'h0};
    vecs[3]  = '{"wb42",    1'b1, 32'h0000_0042, 3'b000, 32'h00AA_0000, 1'b0, 1, 32'h0};
    vecs[4]  = '{"wh40",    1'b1, 32'h0000_0040, 3'b001, 32'h0000_5566, 1'b0, 1, 32'h0};
    vecs[5]  = '{"r40",     1'b0, 32'h0000_0040, 3'b010, 32'h0,         1'b0, 1, 32'h11AA_5566};
    vecs[6]  = '{"w41err",  1'b1, 32'h0000_0041, 3'b010, 32'hFFFF_FFFF, 1'b1, 1, 32'h0};
    vecs[7]  = '{"rsz3err", 1'b0, 32'h0000_0040, 3'b011, 32'h0,         1'b1, 1, 32'h0};
    vecs[8]  = '{"r40b",    1'b0, 32'h0000_0040, 3'b010, 32'h0,         1'b0, 1, 32'h11AA_5566};
    vecs[9]  = '{"wh43err", 1'b1, 32'h0000_0043, 3'b001, 32'h0000_FFFF, 1'b1, 1, 32'h0};
    vecs[10] = '{"walias",  1'b1, 32'h0000_1104, 3'b010, 32'hCAFE_F00D, 1'b0, 1, 32'h0};
    vecs[11] = '{"ralias",  1'b0, 32'h0000_0104, 3'b010, 32'h0,         1'b0, 1, 32'hCAFE_F00D};
    vecs[12] = '{"wh42",    1'b1, 32'h0000_0042, 3'b001, 32'h7788_0000, 1'b0, 1, 32'h0};
    vecs[13] = '{"rb43",    1'b0, 32'h0000_0043, 3'b000, 32'h0,         1'b0, 1, 32'h7788_5566};
    vecs[14] = '{"wb41",    1'b1, 32'h0000_0041, 3'b000, 32'h0000_EE00, 1'b0, 1, 32'h0};
    vecs[15] = '{"r40c",    1'b0, 32'h0000_0040, 3'b010, 32'h0,         1'b0, 1, 32'h7788_EE66};

    pv[0] = '{1'b1, 32'h0, 32'hA0A0_0001};
    pv[1] = '{1'b1, 32'h4, 32'hB1B1_0002};
    pv[2] = '{1'b1, 32'h8, 32'hC2C2_0003};
    pv[3] = '{1'b1, 32'hC, 32'hD3D3_0004};
    pv[4] = '{1'b0, 32'hC, 32'hD3D3_0004};
    pv[5] = '{1'b0, 32'h0, 32'hA0A0_0001};
    pv[6] = '{1'b0, 32'h4, 32'hB1B1_0002};
    pv[7] = '{1'b0, 32'h8, 32'hC2C2_0003};

    pre80 = '{"pre80", 1'b1, 32'h0000_0080, 3'b010, 32'h1234_5678, 1'b0, 1, 32'h0};
    rd80  = '{"rd80",  1'b0, 32'h0000_0080, 3'b010, 32'h0,         1'b0, 1, 32'h1234_5678};
    wr80  = '{"wr80",  1'b1, 32'h0000_0080, 3'b010, 32'hBADB_AD00, 1'b0, 1, 32'h0};

    use_ws0 = 1'b0;
    hwdata  = 32'h0;
    bus_idle();

    // Reset and an idle bus.
    #12;
    check("rst/ready1", 32'(hreadyout1), 32'd1);
    check("rst/resp1",  32'(hresp1),     32'd0);
    check("rst/rdata1", hrdata1,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d/ready1", c), 32'(hreadyout1), 32'd1);
      check($sformatf("idle%0d/resp1",  c), 32'(hresp1),     32'd0);
      check($sformatf("idle%0d/rdata1", c), hrdata1,         32'h0);
      check($sformatf("idle%0d/ready0", c), 32'(hreadyout0), 32'd1);
    end

    // One wait state: word, byte and halfword writes, reads, errors and aliasing.
    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Zero wait states: pipelined writes, then reads that start with a
    // read-after-write to the same word.
    repeat (2) @(posedge clk);
    use_ws0 = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("b2b%0d/ready", i-1), 32'(hready), 32'd1);
        check($sformatf("b2b%0d/resp",  i-1), 32'(resp_s), 32'd0);
        if (!pv[i-1].wr) check($sformatf("b2b%0d/rdata", i-1), rdata_s, pv[i-1].data);
      end
      if (i < 8) begin
        hsel = 1'b1; haddr = pv[i].addr; hwrite = pv[i].wr; hsize = 3'b010;
        htrans = (i == 0 || i == 4) ? 2'b10 : 2'b11;
      end else begin
        bus_idle();
      end
      hwdata = (i > 0 && pv[i-1].wr) ? pv[i-1].data : 32'h0;
    end
    @(posedge clk);
    repeat (4) @(posedge clk);
    use_ws0 = 1'b0;

    // Reset in the middle of a write's wait state.
    run_vec(pre80);
    @(negedge clk);
    hsel = 1'b1; haddr = wr80.addr; htrans = 2'b10; hwrite = 1'b1; hsize = wr80.size;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    hwdata = wr80.wdata;
    check("midrst/wait_low", 32'(hreadyout1), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst/ready", 32'(hreadyout1), 32'd1);
    check("midrst/resp",  32'(hresp1),     32'd0);
    check("midrst/rdata", hrdata1,         32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_vec(rd80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
